// File: rtl/node_out_pio_if.sv
// Avalon-MM slave bus bundle for node_out_pio.
//   address    : word address (3 bits)
//   chipselect : chip select
//   write_n    : write strobe, active low
//   writedata  : write data (32 bits)
//   readdata   : registered read data (32 bits), driven by the slave
interface node_out_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/node_out_pio.sv
// Avalon-MM output PIO with atomic bit set/clear and a one-shot pulse generator.
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port : data register OR'ed with the currently pulsed bits
// Register map: 0 DATA, 1 STATUS (busy, count), 2 PULSE_WIDTH, 3 PULSE_TRIG (reads mask),
// 4 OUTSET, 5 OUTCLEAR, 6/7 unused.
module node_out_pio #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  node_out_pio_if.slave         bus,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [DATA_WIDTH-1:0] DataReset = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0]  CntOne    = CNT_WIDTH'(1);

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrStatus   = 3'd1;
  localparam logic [2:0] AddrWidth    = 3'd2;
  localparam logic [2:0] AddrTrig     = 3'd3;
  localparam logic [2:0] AddrOutSet   = 3'd4;
  localparam logic [2:0] AddrOutClear = 3'd5;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  width_q, width_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [31:0]           readdata_q, readdata_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [CNT_WIDTH-1:0]  wd_cnt;
  logic                  unused_wd;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wd_data   = bus.writedata[DATA_WIDTH-1:0];
  assign wd_cnt    = bus.writedata[CNT_WIDTH-1:0];
  // Upper write-data bits are intentionally ignored.
  assign unused_wd = ^bus.writedata;

  // Next-state for registers and pulse engine.
  always_comb begin
    data_d  = data_q;
    mask_d  = mask_q;
    width_d = width_q;
    cnt_d   = cnt_q;

    // Countdown; mask drops on the same edge the count reaches zero, so pulsed bits
    // stay high for exactly pulse_width cycles.
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        mask_d = '0;
      end
    end

    if (wr_en) begin
      case (bus.address)
        AddrData:     data_d  = wd_data;
        AddrWidth:    width_d = wd_cnt;
        AddrOutSet:   data_d  = data_q | wd_data;
        AddrOutClear: data_d  = data_q & ~wd_data;
        AddrTrig: begin
          if (wd_data == '0) begin
            mask_d = '0;
            cnt_d  = '0;
          end else if (width_q != '0) begin
            // Retrigger merges masks and reloads; overrides expiry at this edge.
            mask_d = mask_q | wd_data;
            cnt_d  = width_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux sees pre-write state; result is registered for 1-cycle latency.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      AddrData:   readdata_d[DATA_WIDTH-1:0] = data_q;
      AddrStatus: begin
        readdata_d[CNT_WIDTH-1:0] = cnt_q;
        readdata_d[31]            = (cnt_q != '0);
      end
      AddrWidth:  readdata_d[CNT_WIDTH-1:0]  = width_q;
      AddrTrig:   readdata_d[DATA_WIDTH-1:0] = mask_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q     <= DataReset;
      mask_q     <= '0;
      width_q    <= '0;
      cnt_q      <= '0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      width_q    <= width_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port     = data_q | mask_q;
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_node_out_pio.sv
module tb_node_out_pio;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [7:0]  out;
    logic [31:0] rd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] out_port;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];
  exp_t sb_q[$];

  node_out_pio_if bus ();

  node_out_pio #(
    .DATA_WIDTH (8),
    .RESET_VALUE(32'h3C),
    .CNT_WIDTH  (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic cs, input logic wn, input logic [2:0] addr,
                     input logic [31:0] wd, input logic [7:0] eo, input logic [31:0] er);
    vec_t v;
    v.cs = cs; v.wn = wn; v.addr = addr; v.wd = wd; v.exp_out = eo; v.exp_rd = er;
    vecs.push_back(v);
  endtask

  // Write = chipselect with write_n low; read = idle cycle presenting an address.
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [7:0] eo,
                    input logic [31:0] er);
    add(1'b1, 1'b0, a, d, eo, er);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] eo, input logic [31:0] er);
    add(1'b0, 1'b1, a, 32'h0, eo, er);
  endtask

  // Apply inputs, queue expected outputs, sample 1 time unit after the edge.
  task automatic apply(input string name, input vec_t v);
    exp_t e;
    exp_t got;
    bus.chipselect = v.cs;
    bus.write_n    = v.wn;
    bus.address    = v.addr;
    bus.writedata  = v.wd;
    e.out = v.exp_out;
    e.rd  = v.exp_rd;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({name, "_out"}, {24'h0, out_port}, {24'h0, got.out});
    chk({name, "_rd"}, bus.readdata, got.rd);
  endtask

  initial begin
    vec_t v;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
    reset_n        = 1'b0;

    // Reset and plain register access
    rd(3'd1, 8'h3C, 32'h0);
    rd(3'd3, 8'h3C, 32'h0);
    wr(3'd0, 32'hFFFF_FFA5, 8'hA5, 32'h3C);      // upper bits ignored
    wr(3'd4, 32'h0A, 8'hAF, 32'h0);
    wr(3'd5, 32'h81, 8'h2E, 32'h0);
    rd(3'd0, 8'h2E, 32'h2E);
    rd(3'd4, 8'h2E, 32'h0);
    // Basic pulse, width 3
    wr(3'd0, 32'h00, 8'h00, 32'h2E);
    wr(3'd2, 32'h3, 8'h00, 32'h0);
    rd(3'd2, 8'h00, 32'h3);
    wr(3'd3, 32'h0F, 8'h0F, 32'h0);
    rd(3'd1, 8'h0F, 32'h8000_0003);
    rd(3'd1, 8'h0F, 32'h8000_0002);
    rd(3'd1, 8'h00, 32'h8000_0001);
    rd(3'd1, 8'h00, 32'h0);
    // Zero width: trigger ignored
    wr(3'd2, 32'h0, 8'h00, 32'h3);
    wr(3'd3, 32'hFF, 8'h00, 32'h0);
    rd(3'd1, 8'h00, 32'h0);
    rd(3'd3, 8'h00, 32'h0);
    // chipselect low blocks writes
    add(1'b0, 1'b0, 3'd0, 32'hFF, 8'h00, 32'h0);
    add(1'b0, 1'b0, 3'd2, 32'h5, 8'h00, 32'h0);
    rd(3'd2, 8'h00, 32'h0);
    // Abort
    wr(3'd2, 32'hA, 8'h00, 32'h0);
    wr(3'd3, 32'hF0, 8'hF0, 32'h0);
    rd(3'd1, 8'hF0, 32'h8000_000A);
    rd(3'd1, 8'hF0, 32'h8000_0009);
    wr(3'd3, 32'h00, 8'h00, 32'hF0);
    rd(3'd1, 8'h00, 32'h0);
    // Retrigger: bit0 high 6 cycles, bit4 high 4 cycles
    wr(3'd2, 32'h4, 8'h00, 32'hA);
    wr(3'd3, 32'h01, 8'h01, 32'h0);
    rd(3'd1, 8'h01, 32'h8000_0004);
    wr(3'd3, 32'h10, 8'h11, 32'h01);
    rd(3'd1, 8'h11, 32'h8000_0004);
    rd(3'd1, 8'h11, 32'h8000_0003);
    rd(3'd1, 8'h11, 32'h8000_0002);
    rd(3'd1, 8'h00, 32'h8000_0001);
    // Trigger on the expiry edge reloads; width change while busy ignored by count
    wr(3'd3, 32'h02, 8'h02, 32'h0);
    rd(3'd1, 8'h02, 32'h8000_0004);
    rd(3'd1, 8'h02, 32'h8000_0003);
    rd(3'd1, 8'h02, 32'h8000_0002);
    wr(3'd3, 32'h04, 8'h06, 32'h02);
    rd(3'd1, 8'h06, 32'h8000_0004);
    wr(3'd2, 32'h7, 8'h06, 32'h4);
    rd(3'd1, 8'h06, 32'h8000_0002);
    rd(3'd1, 8'h00, 32'h8000_0001);
    // Data bit overlapping a pulse stays high after expiry
    wr(3'd4, 32'h01, 8'h01, 32'h0);
    wr(3'd3, 32'h03, 8'h03, 32'h0);
    wr(3'd5, 32'h02, 8'h03, 32'h0);
    rd(3'd1, 8'h03, 32'h8000_0006);
    rd(3'd1, 8'h03, 32'h8000_0005);
    rd(3'd1, 8'h03, 32'h8000_0004);
    rd(3'd1, 8'h03, 32'h8000_0003);
    rd(3'd1, 8'h03, 32'h8000_0002);
    rd(3'd1, 8'h01, 32'h8000_0001);
    rd(3'd0, 8'h01, 32'h01);
    // Long pulse, to be cut by reset
    wr(3'd2, 32'h64, 8'h01, 32'h7);
    wr(3'd3, 32'h55, 8'h55, 32'h0);
    rd(3'd1, 8'h55, 32'h8000_0064);
    rd(3'd1, 8'h55, 32'h8000_0063);
    rd(3'd1, 8'h55, 32'h8000_0062);
    rd(3'd1, 8'h55, 32'h8000_0061);

    // Reset: address 0 presented, readdata must still be 0
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {24'h0, out_port}, 32'h3C);
    chk("reset_rd", bus.readdata, 32'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-pulse
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd1;
    reset_n        = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out", {24'h0, out_port}, 32'h3C);
    chk("midrst_rd", bus.readdata, 32'h0);
    reset_n = 1'b1;
    v.cs = 1'b0; v.wn = 1'b1; v.wd = 32'h0; v.exp_out = 8'h3C; v.exp_rd = 32'h0;
    for (int k = 0; k < 6; k++) begin
      v.addr = (k % 2 == 0) ? 3'd1 : 3'd3;
      apply($sformatf("postrst%0d", k), v);
    end
    v.addr = 3'd2;
    apply("postrst_width", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
